// File: rtl/telem_tx_if.sv
// telem_tx_if: sample inputs and serial/status outputs of the telemetry
// transmitter. The producer (inertial side / bench) uses the master modport,
// telem_tx itself uses the slave modport.
interface telem_tx_if;
    logic        vld;
    logic        pwr_up;
    logic [15:0] ptch;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic [11:0] batt;
    logic        TX;
    logic        busy;
    logic [7:0]  drop_cnt;

    modport master (
        output vld, pwr_up, ptch, lft_spd, rght_spd, batt,
        input  TX, busy, drop_cnt
    );

    modport slave (
        input  vld, pwr_up, ptch, lft_spd, rght_spd, batt,
        output TX, busy, drop_cnt
    );
endinterface

// File: rtl/telem_tx.sv
// telem_tx: decimated telemetry frame transmitter over UART 8N1.
// Every DECIM-th accepted vld pulse snapshots the inputs and sends a frame
// of A5 header + four 16-bit big-endian words. Triggers arriving while a
// frame is in flight are counted in a saturating drop counter.
// Optional feature: define TELEM_CHKSUM_EN to append an 8-bit sum of the
// payload bytes as a tenth byte.
// The state register runs one clock ahead of the registered TX line, so TX
// goes low on the edge after capture and busy is released one edge after
// the FSM returns to IDLE, exactly when the last stop bit ends.
module telem_tx #(
    parameter int BAUD_DIV = 2604,
    parameter int DECIM    = 8
) (
    input  logic         clk,
    input  logic         rst,
    telem_tx_if.slave    bus
);

`ifdef TELEM_CHKSUM_EN
    localparam int NBYTES = 10;
`else
    localparam int NBYTES = 9;
`endif

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [7:0]  DEC_LAST  = 8'(DECIM - 1);
    localparam logic [3:0]  BYTE_LAST = 4'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_r;
    logic [15:0] baud_cnt_r;
    logic [2:0]  bit_idx_r;
    logic [3:0]  byte_idx_r;
    logic [7:0]  dec_cnt_r;
    logic [7:0]  drop_cnt_r;
    logic        tx_r;
    logic        busy_r;
    logic [15:0] snap_ptch_r;
    logic [15:0] snap_lft_r;
    logic [15:0] snap_rght_r;
    logic [15:0] snap_batt_r;

    logic        accept_s;
    logic        trig_s;
    logic        baud_end_s;
    logic [7:0]  cur_byte_s;

`ifdef TELEM_CHKSUM_EN
    // Modulo-256 sum of the eight payload bytes.
    function automatic logic [7:0] frame_chksum(input logic [15:0] w0,
                                                input logic [15:0] w1,
                                                input logic [15:0] w2,
                                                input logic [15:0] w3);
        logic [7:0] sum;
        sum = w0[15:8] + w0[7:0];
        sum = sum + w1[15:8] + w1[7:0];
        sum = sum + w2[15:8] + w2[7:0];
        sum = sum + w3[15:8] + w3[7:0];
        return sum;
    endfunction
`endif

    assign accept_s   = bus.vld & bus.pwr_up;
    assign trig_s     = accept_s & (dec_cnt_r == DEC_LAST);
    assign baud_end_s = (baud_cnt_r == BAUD_LAST);

    // Select the frame byte addressed by the byte index.
    always_comb begin
        cur_byte_s = 8'h00;
        case (byte_idx_r)
            4'd0:    cur_byte_s = 8'hA5;
            4'd1:    cur_byte_s = snap_ptch_r[15:8];
            4'd2:    cur_byte_s = snap_ptch_r[7:0];
            4'd3:    cur_byte_s = snap_lft_r[15:8];
            4'd4:    cur_byte_s = snap_lft_r[7:0];
            4'd5:    cur_byte_s = snap_rght_r[15:8];
            4'd6:    cur_byte_s = snap_rght_r[7:0];
            4'd7:    cur_byte_s = snap_batt_r[15:8];
            4'd8:    cur_byte_s = snap_batt_r[7:0];
`ifdef TELEM_CHKSUM_EN
            4'd9:    cur_byte_s = frame_chksum(snap_ptch_r, snap_lft_r,
                                               snap_rght_r, snap_batt_r);
`endif
            default: cur_byte_s = 8'h00;
        endcase
    end

    // Decimation counter and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cnt_r  <= 8'd0;
            drop_cnt_r <= 8'd0;
        end else begin
            if (accept_s) begin
                if (trig_s) begin
                    dec_cnt_r <= 8'd0;
                end else begin
                    dec_cnt_r <= dec_cnt_r + 8'd1;
                end
            end
            if (trig_s && busy_r && (drop_cnt_r != 8'hFF)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end
        end
    end

    // Frame FSM: snapshot capture, bit timing and registered TX/busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            baud_cnt_r  <= 16'd0;
            bit_idx_r   <= 3'd0;
            byte_idx_r  <= 4'd0;
            tx_r        <= 1'b1;
            busy_r      <= 1'b0;
            snap_ptch_r <= 16'd0;
            snap_lft_r  <= 16'd0;
            snap_rght_r <= 16'd0;
            snap_batt_r <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    tx_r <= 1'b1;
                    if (trig_s && !busy_r) begin
                        snap_ptch_r <= bus.ptch;
                        snap_lft_r  <= {{4{bus.lft_spd[11]}}, bus.lft_spd};
                        snap_rght_r <= {{4{bus.rght_spd[11]}}, bus.rght_spd};
                        snap_batt_r <= {4'h0, bus.batt};
                        busy_r      <= 1'b1;
                        baud_cnt_r  <= 16'd0;
                        byte_idx_r  <= 4'd0;
                        state_r     <= START;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                START: begin
                    tx_r <= 1'b0;
                    if (baud_end_s) begin
                        baud_cnt_r <= 16'd0;
                        bit_idx_r  <= 3'd0;
                        state_r    <= DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                DATA: begin
                    tx_r <= cur_byte_s[bit_idx_r];
                    if (baud_end_s) begin
                        baud_cnt_r <= 16'd0;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                STOP: begin
                    tx_r <= 1'b1;
                    if (baud_end_s) begin
                        baud_cnt_r <= 16'd0;
                        if (byte_idx_r == BYTE_LAST) begin
                            state_r <= IDLE;
                        end else begin
                            byte_idx_r <= byte_idx_r + 4'd1;
                            state_r    <= START;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.TX       = tx_r;
    assign bus.busy     = busy_r;
    assign bus.drop_cnt = drop_cnt_r;

endmodule
